// File: rtl/main_ctrl_pkg.sv
// Shared types and codes for the multicycle RV32I main control FSM.
// State encodings, opcodes, instruction classes and datapath select codes.
package main_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXEC_R    = 4'd7,
      S_EXEC_I    = 4'd8,
      S_ALU_WB    = 4'd9,
      S_BRANCH    = 4'd10,
      S_TRAP      = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      C_LOAD    = 3'd0,
      C_STORE   = 3'd1,
      C_RTYPE   = 3'd2,
      C_ITYPE   = 3'd3,
      C_BRANCH  = 3'd4,
      C_ILLEGAL = 3'd5
   } iclass_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [2:0] F3_BEQ = 3'b000;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       adr_src;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] alu_op;
      logic [3:0] funct;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Unified instruction/data memory request handshake.
// master = control FSM, slave = memory.
interface multicycle_main_control_if;
   logic mem_req;
   logic mem_we;
   logic adr_src;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output adr_src,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  adr_src,
      output mem_ready
   );
endinterface

// File: rtl/main_ctrl_opcode_decode.sv
// Combinational opcode to instruction-class decoder.
module main_ctrl_opcode_decode
   import main_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output iclass_t    iclass
);

   always_comb begin
      iclass = C_ILLEGAL;
      unique case (1'b1)
         (opcode == OP_LOAD):   iclass = C_LOAD;
         (opcode == OP_STORE):  iclass = C_STORE;
         (opcode == OP_RTYPE):  iclass = C_RTYPE;
         (opcode == OP_ITYPE):  iclass = C_ITYPE;
         (opcode == OP_BRANCH): iclass = C_BRANCH;
         default:               iclass = C_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle RV32I main control FSM (fetch/decode/execute/mem/writeback).
// Define MAIN_CTRL_RETIRE_CNT_EN to add the instret retired-instruction counter.
module multicycle_main_control
   import main_ctrl_pkg::*;
#(
   parameter int RETIRE_W    = 32,
   parameter bit TRAP_STICKY = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   multicycle_main_control_if.master mem,
   input  logic [6:0]                opcode,
   input  logic [2:0]                funct3,
   input  logic                      funct7_b5,
   input  logic                      zero,
   output logic                      ir_write,
   output logic                      pc_write,
   output logic                      reg_write,
   output logic [1:0]                alu_src_a,
   output logic [1:0]                alu_src_b,
   output logic [1:0]                result_src,
   output logic [1:0]                ALUOp,
   output logic [3:0]                Funct,
   output logic                      illegal,
`ifdef MAIN_CTRL_RETIRE_CNT_EN
   output logic [RETIRE_W-1:0]       instret,
`endif
   output logic [3:0]                state
);

   state_t  r_state;
   state_t  w_next;
   iclass_t w_iclass;
   ctrl_t   w_ctrl;

   main_ctrl_opcode_decode u_dec (
      .opcode (opcode),
      .iclass (w_iclass)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH:  if (mem.mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            unique case (w_iclass)
               C_LOAD, C_STORE: w_next = S_MEM_ADDR;
               C_RTYPE:         w_next = S_EXEC_R;
               C_ITYPE:         w_next = S_EXEC_I;
               C_BRANCH:        w_next = S_BRANCH;
               default:         w_next = S_TRAP;
            endcase
         end
         S_MEM_ADDR: begin
            if (w_iclass == C_STORE) w_next = S_MEM_WRITE;
            else                     w_next = S_MEM_READ;
         end
         S_MEM_READ:  if (mem.mem_ready) w_next = S_MEM_WB;
         S_MEM_WB:    w_next = S_FETCH;
         S_MEM_WRITE: if (mem.mem_ready) w_next = S_FETCH;
         S_EXEC_R:    w_next = S_ALU_WB;
         S_EXEC_I:    w_next = S_ALU_WB;
         S_ALU_WB:    w_next = S_FETCH;
         S_BRANCH:    w_next = S_FETCH;
         S_TRAP:      if (!TRAP_STICKY) w_next = S_FETCH;
         default:     w_next = S_IDLE;
      endcase
   end

   // Moore decode; ir_write/pc_write in FETCH and BRANCH are the Mealy terms
   always_comb begin
      w_ctrl = '0;
      unique case (r_state)
         S_FETCH: begin
            w_ctrl.mem_req   = 1'b1;
            w_ctrl.alu_src_a = SRCA_PC;
            w_ctrl.alu_src_b = SRCB_FOUR;
            w_ctrl.alu_op    = ALUOP_ADD;
            w_ctrl.ir_write  = mem.mem_ready;
            w_ctrl.pc_write  = mem.mem_ready;
         end
         S_DECODE: begin
            w_ctrl.alu_src_a = SRCA_OLDPC;
            w_ctrl.alu_src_b = SRCB_IMM;
            w_ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_ADDR: begin
            w_ctrl.alu_src_a = SRCA_RS1;
            w_ctrl.alu_src_b = SRCB_IMM;
            w_ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_READ: begin
            w_ctrl.mem_req = 1'b1;
            w_ctrl.adr_src = 1'b1;
         end
         S_MEM_WB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.result_src = RES_MEM;
         end
         S_MEM_WRITE: begin
            w_ctrl.mem_req = 1'b1;
            w_ctrl.mem_we  = 1'b1;
            w_ctrl.adr_src = 1'b1;
         end
         S_EXEC_R: begin
            w_ctrl.alu_src_a = SRCA_RS1;
            w_ctrl.alu_src_b = SRCB_RS2;
            w_ctrl.alu_op    = ALUOP_FUNCT;
            w_ctrl.funct     = {funct7_b5, funct3};
         end
         S_EXEC_I: begin
            // bit 30 is immediate data for addi, never a subtract
            w_ctrl.alu_src_a = SRCA_RS1;
            w_ctrl.alu_src_b = SRCB_IMM;
            w_ctrl.alu_op    = ALUOP_FUNCT;
            w_ctrl.funct     = {1'b0, funct3};
         end
         S_ALU_WB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.result_src = RES_ALUOUT;
         end
         S_BRANCH: begin
            w_ctrl.alu_src_a  = SRCA_RS1;
            w_ctrl.alu_src_b  = SRCB_RS2;
            w_ctrl.alu_op     = ALUOP_SUB;
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.pc_write   = zero & (funct3 == F3_BEQ);
         end
         S_TRAP:  w_ctrl.illegal = 1'b1;
         default: w_ctrl = '0;
      endcase
   end

   assign mem.mem_req = w_ctrl.mem_req;
   assign mem.mem_we  = w_ctrl.mem_we;
   assign mem.adr_src = w_ctrl.adr_src;
   assign ir_write    = w_ctrl.ir_write;
   assign pc_write    = w_ctrl.pc_write;
   assign reg_write   = w_ctrl.reg_write;
   assign alu_src_a   = w_ctrl.alu_src_a;
   assign alu_src_b   = w_ctrl.alu_src_b;
   assign result_src  = w_ctrl.result_src;
   assign ALUOp       = w_ctrl.alu_op;
   assign Funct       = w_ctrl.funct;
   assign illegal     = w_ctrl.illegal;
   assign state       = r_state;

`ifdef MAIN_CTRL_RETIRE_CNT_EN
   logic                w_retire;
   logic [RETIRE_W-1:0] r_instret;

   assign w_retire = (w_next == S_FETCH) &&
                     ((r_state == S_MEM_WB)    ||
                      (r_state == S_MEM_WRITE) ||
                      (r_state == S_ALU_WB)    ||
                      (r_state == S_BRANCH));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      r_instret <= '0;
      else if (w_retire) r_instret <= r_instret + 1'b1;
   end

   assign instret = r_instret;
`endif

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM for the RV32I core; the upstream producer of the 2-bit ALUOp / 4-bit Funct pair that the ALU control decoder consumes.
- Sequences fetch/decode/execute/memory/writeback per instruction.
- Drives datapath mux selects and write enables.
- Handshakes with unified instruction/data memory via mem_req/mem_ready.

Parameters:
RETIRE_W, 32, width of optional retired-instruction counter.
TRAP_STICKY, 1, 1: TRAP held until reset; 0: TRAP returns to FETCH next cycle.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
opcode  in  7  instruction-register bits [6:0].
funct3  in  3  instruction-register bits [14:12].
funct7_b5  in  1  instruction-register bit 30.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current request.
mem_req  out  1  memory request, held until mem_ready.
mem_we  out  1  write qualifier for mem_req.
adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
ir_write  out  1  load instruction register.
pc_write  out  1  load PC.
reg_write  out  1  register-file write enable.
alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1.
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
result_src  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result.
ALUOp  out  2  00 = add, 01 = subtract, 10 = funct-decoded.
Funct  out  4  {funct7_b5, funct3} for the ALU control decoder.
illegal  out  1  unsupported opcode trapped.
state  out  4  current state, for debug.

Behaviour:
- Reset: asynchronous assertion forces state to IDLE immediately, including mid-stall. In IDLE every output is 0.
- IDLE always goes to FETCH on the first clock after reset release.
- Outputs are Moore (decoded from the state register) except the Mealy terms noted below.
- Outputs not listed for a state are 0, including Funct = 4'b0000.
- Memory handshake:
  - mem_req is high for the whole of a memory state.
  - Transfer completes in the cycle mem_ready = 1.
  - mem_ready is ignored while mem_req = 0.
  - No timeout; the FSM stalls indefinitely.
- States and transitions:
  - FETCH: mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, ALUOp = 00. ir_write and pc_write = mem_ready (Mealy). Go to DECODE on mem_ready, else stay.
  - DECODE: alu_src_a = 01, alu_src_b = 01, ALUOp = 00 (branch target). Next state by opcode:
    - 0000011 (load) or 0100011 (store) -> MEM_ADDR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - any other opcode -> TRAP
  - MEM_ADDR: alu_src_a = 10, alu_src_b = 01, ALUOp = 00. Load -> MEM_READ, store -> MEM_WRITE.
  - MEM_READ: mem_req = 1, adr_src = 1. Go to MEM_WB on mem_ready.
  - MEM_WB: reg_write = 1, result_src = 01. Go to FETCH.
  - MEM_WRITE: mem_req = 1, mem_we = 1, adr_src = 1. Go to FETCH on mem_ready.
  - EXEC_R: alu_src_a = 10, alu_src_b = 00, ALUOp = 10, Funct = {funct7_b5, funct3}. Go to ALU_WB.
  - EXEC_I: alu_src_a = 10, alu_src_b = 01, ALUOp = 10, Funct = {1'b0, funct3} (addi never subtracts). Go to ALU_WB.
  - ALU_WB: reg_write = 1, result_src = 00. Go to FETCH.
  - BRANCH: alu_src_a = 10, alu_src_b = 00, ALUOp = 01, result_src = 00. pc_write = zero & (funct3 == 3'b000) (beq only; other funct3 values never branch). Go to FETCH.
  - TRAP: illegal = 1, all other outputs 0. TRAP_STICKY = 1: stay until reset. TRAP_STICKY = 0: go to FETCH.
- Latency (cycles, with zero-wait memory): R/I = 4, load = 5, store = 4, branch = 3.
- opcode/funct inputs are only sampled in DECODE and later, while IR is stable.
- Never assert reg_write and mem_we together, nor ir_write outside FETCH.

Optional Feature:
- Macro: MAIN_CTRL_RETIRE_CNT_EN.
- Defined:
  - Adds output instret [RETIRE_W-1:0], reset to 0.
  - Increments on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB or BRANCH.
  - Wraps to 0 at overflow; never counts IDLE->FETCH or TRAP exits.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package main_ctrl_pkg holds:
  - 4-bit state encodings
  - opcode constants
  - ALUOp codes (00/01/10)
  - alu_src_a/alu_src_b/result_src select codes
- One combinational sub-module, main_ctrl_opcode_decode: opcode -> instruction class (LOAD, STORE, RTYPE, ITYPE, BRANCH, ILLEGAL), used by the DECODE transition.

Test Plan:
- Reset mid-FETCH with mem_req = 1: deassert reset_n -> state = IDLE and all outputs 0 in the same cycle; one cycle after release -> FETCH with mem_req = 1.
- R-type sub (opcode 0110011, funct7_b5 = 1, funct3 = 000), mem_ready tied 1 -> EXEC_R shows ALUOp = 10, Funct = 1000; ALU_WB reg_write = 1; back in FETCH after 4 cycles.
- addi with funct7_b5 = 1 (opcode 0010011, funct3 = 000) -> EXEC_I Funct = 0000, alu_src_b = 01.
- Load with mem_ready low 3 cycles in FETCH and 2 in MEM_READ -> mem_req held high throughout, ir_write pulses once; MEM_WB result_src = 01; total 10 cycles.
- beq with zero = 1 then zero = 0 -> BRANCH ALUOp = 01; pc_write = 1 and 0 respectively; funct3 = 001 with zero = 1 -> pc_write = 0.
- Opcode 1111111 -> TRAP, illegal = 1 held 20 cycles (TRAP_STICKY = 1). With MAIN_CTRL_RETIRE_CNT_EN: after 3 retired instructions, instret = 3 and unchanged by the trap.
